// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one instruction, issues a data-memory load or store, retires it.
// Optional store-to-load forwarding buffer is enabled by defining MEM_STAGE_STORE_FWD_EN.
module mem_stage #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int IALU_WORD_WIDTH = 16,
  parameter int PC_WIDTH        = 12,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic                       in_act_write_res_to_reg,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
  input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [IALU_WORD_WIDTH-1:0] in_res,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  output logic                       out_stall,
  output logic                       out_dmem_rd_req,
  output logic                       out_dmem_wr_req,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_rd_addr,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_wr_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wr_word,
  input  logic                       in_dmem_rd_ack,
  input  logic                       in_dmem_wr_ack,
  input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rd_word,
  output logic                       out_act_write_res_to_reg,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
  output logic [PMEM_WORD_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]        out_pc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic [1:0]                 state, state_d;
  logic                       h_load, h_write;
  logic [DMEM_ADDR_WIDTH-1:0] h_rd_addr, h_wr_addr;
  logic [DMEM_WORD_WIDTH-1:0] h_wr_word;
  logic [PMEM_WORD_WIDTH-1:0] h_instr;
  logic [PC_WIDTH-1:0]        h_pc;
  logic [IALU_WORD_WIDTH-1:0] h_res;
  logic [REG_IDX_WIDTH-1:0]   h_idx;

  logic                       fwd_hit;
  logic                       complete;
  logic [DMEM_WORD_WIDTH-1:0] load_word;
  logic [IALU_WORD_WIDTH-1:0] load_ext;
  logic [IALU_WORD_WIDTH-1:0] wb_val;

  assign out_stall = ((state == LOAD) && !in_dmem_rd_ack) ||
                     ((state == STORE) && !in_dmem_wr_ack);

  assign out_dmem_rd_req  = (state == LOAD);
  assign out_dmem_rd_addr = (state == LOAD) ? h_rd_addr : '0;
  assign out_dmem_wr_req  = (state == STORE);
  assign out_dmem_wr_addr = (state == STORE) ? h_wr_addr : '0;
  assign out_dmem_wr_word = (state == STORE) ? h_wr_word : '0;

  assign complete = (state == IDLE) || ((state == LOAD) && in_dmem_rd_ack) ||
                    ((state == STORE) && in_dmem_wr_ack);

`ifdef MEM_STAGE_STORE_FWD_EN
  logic                       buf_valid, buf_valid_d;
  logic [DMEM_ADDR_WIDTH-1:0] buf_addr, buf_addr_d;
  logic [DMEM_WORD_WIDTH-1:0] buf_word, buf_word_d;
  logic                       h_fwd;
  logic [DMEM_WORD_WIDTH-1:0] h_fwd_word;

  // The store acknowledged this cycle is already visible to a load captured at the same edge.
  always_comb begin
    buf_valid_d = buf_valid;
    buf_addr_d  = buf_addr;
    buf_word_d  = buf_word;
    if ((state == STORE) && in_dmem_wr_ack) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = h_wr_addr;
      buf_word_d  = h_wr_word;
    end
  end

  assign fwd_hit   = in_act_load_dmem && buf_valid_d && (buf_addr_d == in_dmem_rd_addr);
  assign load_word = h_fwd ? h_fwd_word : in_dmem_rd_word;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid  <= 1'b0;
      buf_addr   <= '0;
      buf_word   <= '0;
      h_fwd      <= 1'b0;
      h_fwd_word <= '0;
    end else begin
      buf_valid <= buf_valid_d;
      buf_addr  <= buf_addr_d;
      buf_word  <= buf_word_d;
      if (!out_stall) begin
        h_fwd      <= fwd_hit;
        h_fwd_word <= buf_word_d;
      end
    end
  end
`else
  assign fwd_hit   = 1'b0;
  assign load_word = in_dmem_rd_word;
`endif

  generate
    if (DMEM_WORD_WIDTH >= IALU_WORD_WIDTH) begin : g_trunc
      assign load_ext = load_word[IALU_WORD_WIDTH-1:0];
    end else begin : g_zext
      assign load_ext = {{(IALU_WORD_WIDTH - DMEM_WORD_WIDTH){1'b0}}, load_word};
    end
  endgenerate

  assign wb_val = h_load ? load_ext : h_res;

  // A load with the store flag also set is executed as a load only.
  always_comb begin
    state_d = IDLE;
    if (in_act_load_dmem) begin
      state_d = fwd_hit ? IDLE : LOAD;
    end else if (in_act_store_dmem) begin
      state_d = STORE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                    <= IDLE;
      h_load                   <= 1'b0;
      h_write                  <= 1'b0;
      h_rd_addr                <= '0;
      h_wr_addr                <= '0;
      h_wr_word                <= '0;
      h_instr                  <= '0;
      h_pc                     <= '0;
      h_res                    <= '0;
      h_idx                    <= '0;
      out_act_write_res_to_reg <= 1'b0;
      out_res                  <= '0;
      out_res_reg_idx          <= '0;
      out_instr                <= '0;
      out_pc                   <= '0;
    end else begin
      if (!out_stall) begin
        state     <= state_d;
        h_load    <= in_act_load_dmem;
        h_write   <= in_act_write_res_to_reg;
        h_rd_addr <= in_dmem_rd_addr;
        h_wr_addr <= in_dmem_wr_addr;
        h_wr_word <= in_dmem_wr_word;
        h_instr   <= in_instr;
        h_pc      <= in_pc;
        h_res     <= in_res;
        h_idx     <= in_res_reg_idx;
      end
      if (complete) begin
        out_act_write_res_to_reg <= h_write;
        out_res                  <= wb_val;
        out_res_reg_idx          <= h_idx;
        out_instr                <= h_instr;
        out_pc                   <= h_pc;
      end else begin
        out_act_write_res_to_reg <= 1'b0;
        out_res                  <= '0;
        out_res_reg_idx          <= '0;
        out_instr                <= '0;
        out_pc                   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized op streams vs a
// transaction-level model; forwarding expectations follow MEM_STAGE_STORE_FWD_EN.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg;
  logic [11:0] in_dmem_rd_addr, in_dmem_wr_addr;
  logic [15:0] in_dmem_wr_word, in_instr, in_res;
  logic [11:0] in_pc;
  logic [3:0]  in_res_reg_idx;
  logic        out_stall, out_dmem_rd_req, out_dmem_wr_req;
  logic [11:0] out_dmem_rd_addr, out_dmem_wr_addr;
  logic [15:0] out_dmem_wr_word;
  logic        in_dmem_rd_ack, in_dmem_wr_ack;
  logic [15:0] in_dmem_rd_word;
  logic        out_act_write_res_to_reg;
  logic [15:0] out_res, out_instr;
  logic [3:0]  out_res_reg_idx;
  logic [11:0] out_pc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_stage dut (
    .clock                   (clock),
    .reset                   (reset),
    .in_act_load_dmem        (in_act_load_dmem),
    .in_act_store_dmem       (in_act_store_dmem),
    .in_act_write_res_to_reg (in_act_write_res_to_reg),
    .in_dmem_rd_addr         (in_dmem_rd_addr),
    .in_dmem_wr_addr         (in_dmem_wr_addr),
    .in_dmem_wr_word         (in_dmem_wr_word),
    .in_instr                (in_instr),
    .in_pc                   (in_pc),
    .in_res                  (in_res),
    .in_res_reg_idx          (in_res_reg_idx),
    .out_stall               (out_stall),
    .out_dmem_rd_req         (out_dmem_rd_req),
    .out_dmem_wr_req         (out_dmem_wr_req),
    .out_dmem_rd_addr        (out_dmem_rd_addr),
    .out_dmem_wr_addr        (out_dmem_wr_addr),
    .out_dmem_wr_word        (out_dmem_wr_word),
    .in_dmem_rd_ack          (in_dmem_rd_ack),
    .in_dmem_wr_ack          (in_dmem_wr_ack),
    .in_dmem_rd_word         (in_dmem_rd_word),
    .out_act_write_res_to_reg(out_act_write_res_to_reg),
    .out_res                 (out_res),
    .out_res_reg_idx         (out_res_reg_idx),
    .out_instr               (out_instr),
    .out_pc                  (out_pc)
  );

  typedef struct {
    bit          ld, st, wr;
    logic [11:0] ra, wa, pc;
    logic [15:0] ww, instr, res, rdw;
    logic [3:0]  idx;
    int          dly;
  } op_t;

  op_t ops[$];

  // Expected retired record (all zero = bubble) and the store-forwarding model.
  logic [60:0] exp_wb;
  bit          fb_valid;
  logic [11:0] fb_addr;
  logic [15:0] fb_word;

  task automatic drive_op(input op_t o);
    in_act_load_dmem        = o.ld;
    in_act_store_dmem       = o.st;
    in_act_write_res_to_reg = o.wr;
    in_dmem_rd_addr         = o.ra;
    in_dmem_wr_addr         = o.wa;
    in_dmem_wr_word         = o.ww;
    in_instr                = o.instr;
    in_pc                   = o.pc;
    in_res                  = o.res;
    in_res_reg_idx          = o.idx;
  endtask

  task automatic drive_nop();
    op_t o;
    o = '{default: 0};
    drive_op(o);
  endtask

  task automatic drive_junk();
    op_t o;
    o.ld = 1'($urandom); o.st = 1'($urandom); o.wr = 1'($urandom);
    o.ra = 12'($urandom); o.wa = 12'($urandom); o.pc = 12'($urandom);
    o.ww = 16'($urandom); o.instr = 16'($urandom); o.res = 16'($urandom);
    o.rdw = 16'($urandom); o.idx = 4'($urandom); o.dly = 1;
    drive_op(o);
  endtask

  function automatic op_t mk_op(input bit ld, input bit st, input bit wr, input logic [11:0] ra,
                                input logic [11:0] wa, input logic [15:0] ww,
                                input logic [15:0] res, input logic [3:0] idx,
                                input logic [15:0] rdw, input int dly);
    op_t o;
    o.ld = ld; o.st = st; o.wr = wr; o.ra = ra; o.wa = wa; o.ww = ww;
    o.res = res; o.idx = idx; o.rdw = rdw; o.dly = dly;
    o.instr = 16'($urandom); o.pc = 12'($urandom);
    return o;
  endfunction

  // Plays ops[] back to back; memory ops are acked on cycle 'dly' after capture.
  task automatic run_ops();
    op_t         o;
    bit          is_ld, is_st, hit;
    int          d;
    logic [15:0] v;
    drive_op(ops[0]);
    @(posedge clock);
    for (int i = 0; i < ops.size(); i++) begin
      o     = ops[i];
      is_ld = o.ld;
      is_st = o.st && !o.ld;
      hit   = 1'b0;
`ifdef MEM_STAGE_STORE_FWD_EN
      hit = is_ld && fb_valid && (fb_addr == o.ra);
`endif
      d = ((is_ld && !hit) || is_st) ? o.dly : 1;
      for (int k = 1; k <= d; k++) begin
        #1;
        in_dmem_rd_ack  = (is_ld && !hit) ? (k == d) : 1'($urandom);
        in_dmem_wr_ack  = is_st ? (k == d) : 1'($urandom);
        in_dmem_rd_word = (k == d) ? o.rdw : 16'($urandom);
        if (k < d) drive_junk();
        else if (i + 1 < ops.size()) drive_op(ops[i + 1]);
        else drive_nop();
        @(negedge clock);
        checks++;
        if (out_stall !== (k < d)) begin
          errors++;
          $display("FAIL stall op%0d cyc%0d: got %b want %b", i, k, out_stall, (k < d));
        end
        checks++;
        if ({out_dmem_rd_req, out_dmem_rd_addr} !== {is_ld && !hit, (is_ld && !hit) ? o.ra : 12'h0})
        begin
          errors++;
          $display("FAIL rd_req op%0d cyc%0d: got %b/%h want %b/%h", i, k, out_dmem_rd_req,
                   out_dmem_rd_addr, is_ld && !hit, (is_ld && !hit) ? o.ra : 12'h0);
        end
        checks++;
        if ({out_dmem_wr_req, out_dmem_wr_addr, out_dmem_wr_word} !==
            {is_st, is_st ? o.wa : 12'h0, is_st ? o.ww : 16'h0}) begin
          errors++;
          $display("FAIL wr_req op%0d cyc%0d: got %b/%h/%h want %b/%h/%h", i, k, out_dmem_wr_req,
                   out_dmem_wr_addr, out_dmem_wr_word, is_st, o.wa, o.ww);
        end
        checks++;
        if ({out_act_write_res_to_reg, out_res, out_res_reg_idx, out_instr, out_pc} !== exp_wb) begin
          errors++;
          $display("FAIL writeback op%0d cyc%0d: got %h want %h", i, k,
                   {out_act_write_res_to_reg, out_res, out_res_reg_idx, out_instr, out_pc}, exp_wb);
        end
        @(posedge clock);
        if (k == d) begin
          v      = is_ld ? (hit ? fb_word : o.rdw) : o.res;
          exp_wb = {o.wr, v, o.idx, o.instr, o.pc};
          if (is_st) begin
            fb_valid = 1'b1; fb_addr = o.wa; fb_word = o.ww;
          end
        end else begin
          exp_wb = '0;
        end
      end
    end
    #1;
    in_dmem_rd_ack = 1'b0;
    in_dmem_wr_ack = 1'b0;
    @(negedge clock);
    checks++;
    if ({out_act_write_res_to_reg, out_res, out_res_reg_idx, out_instr, out_pc} !== exp_wb) begin
      errors++;
      $display("FAIL writeback last: got %h want %h",
               {out_act_write_res_to_reg, out_res, out_res_reg_idx, out_instr, out_pc}, exp_wb);
    end
    @(posedge clock);
    exp_wb = '0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_nop();
    in_dmem_rd_ack = 1'b0; in_dmem_wr_ack = 1'b0; in_dmem_rd_word = '0;
    exp_wb = '0; fb_valid = 1'b0; fb_addr = '0; fb_word = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({out_stall, out_dmem_rd_req, out_dmem_wr_req, out_dmem_rd_addr, out_dmem_wr_addr,
         out_dmem_wr_word, out_act_write_res_to_reg, out_res, out_res_reg_idx, out_instr,
         out_pc} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got nonzero (stall %b rd %b wr %b res %h) want all 0",
               out_stall, out_dmem_rd_req, out_dmem_wr_req, out_res);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_alu();
    ops.delete();
    ops.push_back(mk_op(0, 0, 1, 12'h0, 12'h0, 16'h0, 16'h1234, 4'd3, 16'h0, 1));
    run_ops();
    @(negedge clock);
    checks++;
    if (out_act_write_res_to_reg !== 1'b0) begin
      errors++;
      $display("FAIL alu following write: got %b want 0", out_act_write_res_to_reg);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_load();
    ops.delete();
    ops.push_back(mk_op(1, 0, 1, 12'h040, 12'h0, 16'h0, 16'h7777, 4'd5, 16'hBEEF, 3));
    run_ops();
  endtask

  task automatic test_store();
    ops.delete();
    ops.push_back(mk_op(0, 1, 0, 12'h0, 12'h010, 16'h00AA, 16'h1111, 4'd2, 16'h0, 1));
    ops.push_back(mk_op(1, 1, 1, 12'h070, 12'h071, 16'h0F0F, 16'h2222, 4'd6, 16'hCAFE, 2));
    run_ops();
  endtask

  task automatic test_store_fwd();
    ops.delete();
    ops.push_back(mk_op(0, 1, 0, 12'h0, 12'h020, 16'h5555, 16'h0, 4'd1, 16'h0, 2));
    ops.push_back(mk_op(1, 0, 1, 12'h020, 12'h0, 16'h0, 16'h0, 4'd7, 16'h9999, 3));
    run_ops();
  endtask

  task automatic test_reset_mid_load();
    drive_op(mk_op(1, 0, 1, 12'h050, 12'h0, 16'h0, 16'h0, 4'd4, 16'h0, 4));
    @(posedge clock);
    #1;
    drive_nop();
    @(negedge clock);
    checks++;
    if (out_dmem_rd_req !== 1'b1 || out_stall !== 1'b1) begin
      errors++;
      $display("FAIL pre-reset load: got req %b stall %b want 1 1", out_dmem_rd_req, out_stall);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_stall, out_dmem_rd_req, out_dmem_wr_req, out_dmem_rd_addr, out_dmem_wr_addr,
         out_dmem_wr_word, out_act_write_res_to_reg, out_res, out_res_reg_idx, out_instr,
         out_pc} !== '0) begin
      errors++;
      $display("FAIL reset mid-load: got req %b stall %b addr %h want all 0", out_dmem_rd_req,
               out_stall, out_dmem_rd_addr);
    end
    exp_wb = '0; fb_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    // Forwarding buffer must have been cleared, so this load goes to memory.
    ops.delete();
    ops.push_back(mk_op(1, 0, 1, 12'h020, 12'h0, 16'h0, 16'h0, 4'd8, 16'h4321, 2));
    run_ops();
  endtask

  task automatic test_random();
    int t;
    ops.delete();
    for (int i = 0; i < 80; i++) begin
      t = $urandom_range(0, 3);
      ops.push_back(mk_op(t == 1 || t == 3, t == 2 || t == 3, 1'($urandom),
                          12'(16 * $urandom_range(1, 4)), 12'(16 * $urandom_range(1, 4)),
                          16'($urandom), 16'($urandom), 4'($urandom), 16'($urandom),
                          $urandom_range(1, 4)));
    end
    run_ops();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_store_fwd();
    test_reset_mid_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameters (name, default, meaning): DMEM_ADDR_WIDTH, 12, data-memory address bits; DMEM_WORD_WIDTH, 16, data word bits; IALU_WORD_WIDTH, 16, result bits; PC_WIDTH, 12, PC bits; PMEM_WORD_WIDTH, 16, instruction bits; REG_IDX_WIDTH, 4, register index bits.
REQ-002 SHALL have ports (name direction width meaning):
- clock  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg  in  1  operation flags from execute.
- in_dmem_rd_addr, in_dmem_wr_addr  in  DMEM_ADDR_WIDTH  load and store addresses.
- in_dmem_wr_word  in  DMEM_WORD_WIDTH  store data.
- in_instr  in  PMEM_WORD_WIDTH  instruction.
- in_pc  in  PC_WIDTH  PC.
- in_res  in  IALU_WORD_WIDTH  ALU result.
- in_res_reg_idx  in  REG_IDX_WIDTH  destination register.
- out_stall  out  1  upstream must hold inputs.
- out_dmem_rd_req, out_dmem_wr_req  out  1  memory requests.
- out_dmem_rd_addr, out_dmem_wr_addr  out  DMEM_ADDR_WIDTH  request addresses.
- out_dmem_wr_word  out  DMEM_WORD_WIDTH  store data.
- in_dmem_rd_ack, in_dmem_wr_ack  in  1  request completion.
- in_dmem_rd_word  in  DMEM_WORD_WIDTH  read data, valid with rd_ack.
- out_act_write_res_to_reg  out  1  writeback enable.
- out_res  out  IALU_WORD_WIDTH  writeback value.
- out_res_reg_idx  out  REG_IDX_WIDTH  writeback register.
- out_instr  out  PMEM_WORD_WIDTH  retired instruction.
- out_pc  out  PC_WIDTH  retired PC.

Function
REQ-003 SHALL capture all inputs into a holding register on each rising edge where out_stall=0; hold them while out_stall=1.
REQ-004 SHALL run FSM states IDLE, LOAD, STORE; next state on capture = LOAD if captured load flag, else STORE if store flag, else IDLE.
REQ-005 Load and store both set SHALL be executed as load only.
REQ-006 In LOAD, out_dmem_rd_req=1 and out_dmem_rd_addr=held address; in STORE, out_dmem_wr_req=1 with held address and word; all request outputs SHALL be 0 otherwise.
REQ-007 out_stall SHALL be (LOAD and not rd_ack) or (STORE and not wr_ack), combinationally; ack cycle accepts next input.
REQ-008 Writeback outputs SHALL be registered and load on every edge: completing instruction (IDLE, or LOAD/STORE with ack) loads its fields, otherwise a bubble (all zero).
REQ-009 Writeback value SHALL be in_dmem_rd_word (zero-extended/truncated to IALU_WORD_WIDTH) for loads, held in_res otherwise.
REQ-010 Latency: non-memory op captured at edge N appears at writeback after edge N+1; memory op appears after the edge ending its ack cycle.
REQ-011 Ack arriving in a state not expecting it SHALL be ignored.

Reset
REQ-012 Reset SHALL immediately force FSM to IDLE, holding register and all outputs to 0, including mid-request (requests drop without waiting for ack).

Configuration
REQ-013 Macro MEM_STAGE_STORE_FWD_EN: when defined, a one-entry buffer records address/word of the last acknowledged store; a load whose address matches a valid entry SHALL complete in IDLE timing (no rd_req, no stall) with buffered word; buffer valid cleared by reset. When undefined, no buffer exists and every load issues rd_req.

Verification
REQ-014 ALU op in_res=0x1234, reg 3, write=1 -> next cycle out_res=0x1234, out_res_reg_idx=3, write=1; following cycle write=0.
REQ-015 Load addr 0x040, rd_ack after 3 cycles with word 0xBEEF -> rd_req high 3 cycles, out_stall high 2 cycles, then out_res=0xBEEF.
REQ-016 Store addr 0x010 word 0x00AA, wr_ack same cycle -> wr_req one cycle, out_stall=0, write=0 at writeback.
REQ-017 Reset asserted during LOAD wait -> rd_req and out_stall 0 immediately; all outputs 0.
REQ-018 With MEM_STAGE_STORE_FWD_EN: store 0x020/0x5555 acked, then load 0x020 -> no rd_req, out_res=0x5555 next cycle; without macro, rd_req asserted.
